// File: rtl/pixel_capture_fifo.sv
// pixel_capture_fifo: captures ADC words on pixel strobes inside the ADC frame
// window into a FIFO. A Wishbone slave gives access to the FIFO head, status,
// control and per-frame pixel statistics, and drives a level interrupt.
module pixel_capture_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16
) (
    input  logic              i_wb_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_addr,
    input  logic [31:0]       i_wb_data,
    output logic              o_wb_ack,
    output logic [31:0]       o_wb_data,
    input  logic              i_adc_frame,
    input  logic              i_pixel_flag,
    input  logic [DATA_W-1:0] i_adc_data,
    output logic              o_irq,
    output logic              o_fifo_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;
    logic              fd_q, fd_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       pixcnt_q, pixcnt_d;
    logic [15:0]       run_cnt_q, run_cnt_d;
    logic              frame_prev_q;
    logic              pix_prev_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic        wb_req_s, wb_rd_s, wb_wr_s;
    logic [1:0]  addr_s;
    logic        empty_s, full_s, pop_s, clear_s;
    logic        frame_rise_s, pix_event_s, in_capture_s;
    logic        push_req_s, push_ok_s, frame_end_s;
    logic        w1c_ovf_s, w1c_fd_s, ctrl_wr_s;
    logic [31:0] head_word_s;
    logic        wb_unused_s;

    // Only address bits [3:2] and a few write-data bits carry meaning.
    assign wb_unused_s = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_data[31:13], i_wb_data[10:3]};

    assign wb_req_s = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wb_rd_s  = wb_req_s & ~i_wb_we;
    assign wb_wr_s  = wb_req_s & i_wb_we;
    assign addr_s   = i_wb_addr[3:2];

    assign empty_s   = (count_q == {CW{1'b0}});
    assign full_s    = (count_q == CW'(DEPTH));
    assign pop_s     = wb_rd_s & (addr_s == 2'd0) & ~empty_s;
    assign clear_s   = wb_wr_s & (addr_s == 2'd2) & i_wb_data[2];
    assign ctrl_wr_s = wb_wr_s & (addr_s == 2'd2);
    assign w1c_ovf_s = wb_wr_s & (addr_s == 2'd1) & i_wb_data[11];
    assign w1c_fd_s  = wb_wr_s & (addr_s == 2'd1) & i_wb_data[12];

    // A pixel event is a strobe rising edge seen inside the frame window; the
    // frame-rise cycle already belongs to the capture window.
    assign frame_rise_s = i_adc_frame & ~frame_prev_q;
    assign pix_event_s  = i_pixel_flag & ~pix_prev_q & i_adc_frame;
    assign in_capture_s = enable_q & ((state_q == ST_CAPTURE) | (state_q != ST_CAPTURE & frame_rise_s));
    assign frame_end_s  = enable_q & (state_q == ST_CAPTURE) & ~i_adc_frame;
    assign push_req_s   = in_capture_s & pix_event_s;
    assign push_ok_s    = push_req_s & ~clear_s & (~full_s | pop_s);

    assign head_word_s  = {1'b1, 31'(mem_q[rd_ptr_q])};

    assign o_wb_ack     = ack_q;
    assign o_wb_data    = rdata_q;
    assign o_irq        = irq_en_q & (fd_q | ovf_q);
    assign o_fifo_empty = empty_s;

    // Capture FSM next state: disable forces IDLE, otherwise track frame edges.
    always_comb begin
        state_d = state_q;
        if (!enable_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = frame_rise_s ? ST_CAPTURE : ST_ARMED;
                ST_ARMED:   state_d = frame_rise_s ? ST_CAPTURE : ST_ARMED;
                ST_CAPTURE: state_d = i_adc_frame ? ST_CAPTURE : ST_ARMED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Register-file, statistics and FIFO pointer next-state logic.
    always_comb begin
        ack_d       = wb_req_s;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        ovf_d       = ovf_q;
        fd_d        = fd_q;
        frame_cnt_d = frame_cnt_q;
        pixcnt_d    = pixcnt_q;
        run_cnt_d   = run_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rdata_d     = 32'h0000_0000;

        if (ctrl_wr_s) begin
            enable_d = i_wb_data[0];
            irq_en_d = i_wb_data[1];
        end else begin
            enable_d = enable_q;
        end

        // Running pixel count; a disable discards the partial frame.
        if (!enable_q) begin
            run_cnt_d = 16'h0000;
        end else if (frame_end_s) begin
            pixcnt_d    = run_cnt_q;
            frame_cnt_d = frame_cnt_q + 16'h0001;
            run_cnt_d   = 16'h0000;
        end else if (push_req_s && (run_cnt_q != 16'hFFFF)) begin
            run_cnt_d = run_cnt_q + 16'h0001;
        end else begin
            run_cnt_d = run_cnt_q;
        end

        // Sticky flags: the clear is applied first so a same-cycle set wins.
        if (w1c_ovf_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (push_req_s && !clear_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end
        if (w1c_fd_s) begin
            fd_d = 1'b0;
        end else begin
            fd_d = fd_q;
        end
        if (frame_end_s) begin
            fd_d = 1'b1;
        end else begin
            fd_d = fd_d;
        end

        // FIFO bookkeeping; clear overrides both push and pop.
        if (clear_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_ok_s);
            rd_ptr_d = rd_ptr_q + AW'(pop_s);
            count_d  = count_q + CW'(push_ok_s) - CW'(pop_s);
        end

        if (wb_rd_s) begin
            case (addr_s)
                2'd0:    rdata_d = empty_s ? 32'h0000_0000 : head_word_s;
                2'd1:    rdata_d = {frame_cnt_q, 3'b000, fd_q, ovf_q, full_s, empty_s, 9'(count_q)};
                2'd2:    rdata_d = {29'h0000_0000, 1'b0, irq_en_q, enable_q};
                2'd3:    rdata_d = {16'h0000, pixcnt_q};
                default: rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Control, status, statistics and bus response registers.
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            ack_q        <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            ovf_q        <= 1'b0;
            fd_q         <= 1'b0;
            frame_cnt_q  <= 16'h0000;
            pixcnt_q     <= 16'h0000;
            run_cnt_q    <= 16'h0000;
            frame_prev_q <= 1'b0;
            pix_prev_q   <= 1'b0;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            enable_q     <= enable_d;
            irq_en_q     <= irq_en_d;
            ovf_q        <= ovf_d;
            fd_q         <= fd_d;
            frame_cnt_q  <= frame_cnt_d;
            pixcnt_q     <= pixcnt_d;
            run_cnt_q    <= run_cnt_d;
            frame_prev_q <= i_adc_frame;
            pix_prev_q   <= i_pixel_flag;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage, written at the tail on every accepted push.
    always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= i_adc_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_pixel_capture_fifo.sv
// Directed bench for pixel_capture_fifo: a table of bus/frame operations with
// hand-computed register values, plus hand-written multi-cycle corner cases.
module tb_pixel_capture_fifo;

    localparam int DW = 12;

    localparam logic [2:0] OP_RD  = 3'd0;
    localparam logic [2:0] OP_WR  = 3'd1;
    localparam logic [2:0] OP_FRM = 3'd2;
    localparam logic [2:0] OP_RST = 3'd3;
    localparam logic [2:0] OP_IRQ = 3'd4;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  addr;
        logic [31:0] data;
        int          n;
        logic [31:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]   adr = 32'h0, wdat = 32'h0;
    logic          ack;
    logic [31:0]   rdat;
    logic          frame = 1'b0, pix = 1'b0;
    logic [DW-1:0] adc = '0;
    logic          irq, empty;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    pixel_capture_fifo #(.DATA_W(DW), .DEPTH(16)) dut (
        .i_wb_clk(clk), .i_rst_n(rst_n),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(adr), .i_wb_data(wdat),
        .o_wb_ack(ack), .o_wb_data(rdat),
        .i_adc_frame(frame), .i_pixel_flag(pix), .i_adc_data(adc),
        .o_irq(irq), .o_fifo_empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic wr, input logic [1:0] a, input logic [31:0] d, output logic [31:0] q);
        logic got;
        got = 1'b0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = {28'h0, a, 2'b00}; wdat = d;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        q = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_ack_timeout: got no ack expected ack within 4 cycles (addr %0d)", a);
        end
    endtask

    task automatic wb_rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] q;
        wb_xfer(1'b0, a, 32'h0, q);
        check(name, q, exp);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic frame_rise();
        @(negedge clk);
        frame = 1'b1;
    endtask

    task automatic frame_fall();
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
    endtask

    task automatic pixel(input logic [31:0] d);
        @(negedge clk);
        pix = 1'b1;
        adc = d[DW-1:0];
        @(negedge clk);
        pix = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; frame = 1'b0; pix = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic [2:0] op, input logic [1:0] a, input logic [31:0] d,
                                input int n, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.n = n; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        // Reset state and register defaults.
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0000_0200);
        add(OP_RD, 2'd2, 32'h0, 1, 32'h0000_0000);
        add(OP_RD, 2'd3, 32'h0, 1, 32'h0000_0000);
        add(OP_RD, 2'd0, 32'h0, 1, 32'h0000_0000);
        // Basic capture of five pixels.
        add(OP_WR, 2'd2, 32'h1, 1, 32'h0);
        add(OP_FRM, 2'd0, 32'h101, 5, 32'h0);
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0001_1005);
        add(OP_RD, 2'd0, 32'h0, 5, 32'h8000_0101);
        add(OP_RD, 2'd0, 32'h0, 1, 32'h0000_0000);
        add(OP_RD, 2'd3, 32'h0, 1, 32'h0000_0005);
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0001_1200);
        add(OP_WR, 2'd1, 32'h1000, 1, 32'h0);
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0001_0200);
        // Frame statistics over three frames with interrupt enabled.
        add(OP_RST, 2'd0, 32'h0, 1, 32'h0);
        add(OP_WR, 2'd2, 32'h3, 1, 32'h0);
        add(OP_FRM, 2'd0, 32'h200, 4, 32'h0);
        add(OP_FRM, 2'd0, 32'h210, 4, 32'h0);
        add(OP_FRM, 2'd0, 32'h220, 4, 32'h0);
        add(OP_RD, 2'd3, 32'h0, 1, 32'h0000_0004);
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0003_100C);
        add(OP_IRQ, 2'd0, 32'h0, 1, 32'h1);
        add(OP_WR, 2'd1, 32'h1000, 1, 32'h0);
        add(OP_IRQ, 2'd0, 32'h0, 1, 32'h0);
        add(OP_WR, 2'd2, 32'h7, 1, 32'h0);
        add(OP_RD, 2'd2, 32'h0, 1, 32'h0000_0003);
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0003_0200);
        add(OP_RD, 2'd0, 32'h0, 1, 32'h0000_0000);
        // Overflow: twenty strobes into sixteen entries.
        add(OP_WR, 2'd2, 32'h1, 1, 32'h0);
        add(OP_FRM, 2'd0, 32'h300, 20, 32'h0);
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0004_1C10);
        add(OP_RD, 2'd0, 32'h0, 16, 32'h8000_0300);
        add(OP_RD, 2'd0, 32'h0, 1, 32'h0000_0000);
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0004_1A00);
        add(OP_RD, 2'd3, 32'h0, 1, 32'h0000_0014);
        add(OP_WR, 2'd1, 32'h1800, 1, 32'h0);
        add(OP_RD, 2'd1, 32'h0, 1, 32'h0004_0200);

        // Power-on: force the async reset and look at outputs before any release.
        #2 rst_n = 1'b0;
        #1;
        check("por_ack", {31'h0, ack}, 32'h0);
        check("por_data", rdat, 32'h0);
        check("por_irq", {31'h0, irq}, 32'h0);
        check("por_empty", {31'h0, empty}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            case (vecs[k].op)
                OP_RD: begin
                    for (int j = 0; j < vecs[k].n; j++) begin
                        wb_rd_chk($sformatf("vec%0d_rd%0d_addr%0d", k, j, vecs[k].addr),
                                  vecs[k].addr, vecs[k].exp + 32'(j));
                    end
                end
                OP_WR: wb_wr(vecs[k].addr, vecs[k].data);
                OP_FRM: begin
                    frame_rise();
                    for (int j = 0; j < vecs[k].n; j++) pixel(vecs[k].data + 32'(j));
                    frame_fall();
                end
                OP_RST: do_reset();
                OP_IRQ: begin
                    @(negedge clk);
                    check($sformatf("vec%0d_irq", k), {31'h0, irq}, vecs[k].exp);
                end
                default: begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL vec%0d_op: got bad opcode %0d expected a known opcode", k, vecs[k].op);
                end
            endcase
        end

        // Full FIFO: a pop and a push land on the same edge.
        frame_rise();
        for (int j = 0; j < 16; j++) pixel(32'h400 + 32'(j));
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        pix = 1'b1; adc = 12'h4AA;
        @(negedge clk);
        check("popush_ack", {31'h0, ack}, 32'h1);
        check("popush_data", rdat, 32'h8000_0400);
        cyc = 1'b0; stb = 1'b0; pix = 1'b0;
        frame_fall();
        wb_rd_chk("popush_status", 2'd1, 32'h0005_1410);
        for (int j = 1; j < 16; j++) wb_rd_chk($sformatf("popush_rd%0d", j), 2'd0, 32'h8000_0400 + 32'(j));
        wb_rd_chk("popush_new", 2'd0, 32'h8000_04AA);
        wb_rd_chk("popush_empty", 2'd0, 32'h0);
        wb_wr(2'd1, 32'h1000);
        wb_rd_chk("popush_w1c", 2'd1, 32'h0005_0200);

        // Enable dropped mid-frame, then re-enabled while the frame is still high.
        frame_rise();
        pixel(32'h501);
        pixel(32'h502);
        wb_wr(2'd2, 32'h0);
        pixel(32'h503);
        wb_wr(2'd2, 32'h1);
        pixel(32'h504);
        frame_fall();
        wb_rd_chk("middis_status", 2'd1, 32'h0005_0002);
        wb_rd_chk("middis_pixcnt", 2'd3, 32'h0000_0011);
        frame_rise();
        pixel(32'h505);
        frame_fall();
        wb_rd_chk("rearm_status", 2'd1, 32'h0006_1003);
        wb_rd_chk("rearm_rd0", 2'd0, 32'h8000_0501);
        wb_rd_chk("rearm_rd1", 2'd0, 32'h8000_0502);
        wb_rd_chk("rearm_rd2", 2'd0, 32'h8000_0505);
        wb_rd_chk("rearm_pixcnt", 2'd3, 32'h0000_0001);

        // Async reset mid-capture while an ack is on the bus.
        wb_wr(2'd2, 32'h3);
        @(negedge clk);
        check("arst_irq_pre", {31'h0, irq}, 32'h1);
        frame_rise();
        pixel(32'h600);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
        @(posedge clk);
        #2;
        check("arst_ack_pre", {31'h0, ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_ack", {31'h0, ack}, 32'h0);
        check("arst_data", rdat, 32'h0);
        check("arst_irq", {31'h0, irq}, 32'h0);
        check("arst_empty", {31'h0, empty}, 32'h1);
        cyc = 1'b0; stb = 1'b0; frame = 1'b0; pix = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wb_rd_chk("arst_status", 2'd1, 32'h0000_0200);
        wb_rd_chk("arst_ctrl", 2'd2, 32'h0);
        wb_rd_chk("arst_pixcnt", 2'd3, 32'h0);
        wb_rd_chk("arst_data_rd", 2'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
